// File: rtl/seven_seg_scan_driver.sv
// Four-digit multiplexed common-anode seven-segment driver.
// Inputs are snapshotted once per scan frame so a digit set never tears mid-scan.
module seven_seg_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);

  logic [DW-1:0] div_cnt_r;
  logic [1:0]    sel_r;
  logic [15:0]   snap_value_r;
  logic [3:0]    snap_en_r;
  logic [3:0]    snap_dp_r;
  logic          init_pending_r;

  logic          tick_s;
  logic          load_s;
  logic [3:0]    nibble_s;
  logic          blank_s;
  logic [3:0]    an_s;
  logic [6:0]    seg_s;
  logic          dp_s;

  // Glyph table, active-low segments g..a.
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      4'hF:    g = 7'h0E;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // Slot tick, frame-wrap load strobe and next output values from registered state only.
  always_comb begin
    tick_s   = (div_cnt_r == DIV_LAST);
    load_s   = init_pending_r | (tick_s & (sel_r == 2'd3));
    nibble_s = snap_value_r[{sel_r, 2'b00} +: 4];
    blank_s  = init_pending_r | ~snap_en_r[sel_r];
    if (blank_s) begin
      an_s  = 4'b1111;
      seg_s = 7'h7F;
      dp_s  = 1'b1;
    end else begin
      an_s  = ~(4'b0001 << sel_r);
      seg_s = hex_glyph(nibble_s);
      dp_s  = ~snap_dp_r[sel_r];
    end
  end

  // Divider, digit select, frame snapshot and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r      <= '0;
      sel_r          <= 2'd0;
      snap_value_r   <= 16'h0000;
      snap_en_r      <= 4'b0000;
      snap_dp_r      <= 4'b0000;
      init_pending_r <= 1'b1;
      an             <= 4'b1111;
      seg            <= 7'h7F;
      dp             <= 1'b1;
    end else begin
      div_cnt_r      <= tick_s ? '0 : div_cnt_r + DW'(1);
      sel_r          <= tick_s ? sel_r + 2'd1 : sel_r;
      init_pending_r <= 1'b0;
      if (load_s) begin
        snap_value_r <= value;
        snap_en_r    <= digit_en;
        snap_dp_r    <= dp_in;
      end else begin
        snap_value_r <= snap_value_r;
        snap_en_r    <= snap_en_r;
        snap_dp_r    <= snap_dp_r;
      end
      an  <= an_s;
      seg <= seg_s;
      dp  <= dp_s;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: two instances (REFRESH_DIV=4 and 1) checked every
// cycle against a frame/slot model derived from elapsed cycles since reset.
module tb_seven_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  digit_en;
  logic [3:0]  dp_in;
  logic [3:0]  an4, an1;
  logic [6:0]  seg4, seg1;
  logic        dp4, dp1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(.REFRESH_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .value(value), .digit_en(digit_en), .dp_in(dp_in),
    .an(an4), .seg(seg4), .dp(dp4)
  );

  seven_seg_scan_driver #(.REFRESH_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .value(value), .digit_en(digit_en), .dp_in(dp_in),
    .an(an1), .seg(seg1), .dp(dp1)
  );

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state per instance: t = non-reset edges since reset, plus the current snapshot.
  int          rdiv [2] = '{4, 1};
  int          t_m  [2];
  logic [15:0] sv_m [2];
  logic [3:0]  se_m [2];
  logic [3:0]  sd_m [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cur_sel(input int i);
    return (t_m[i] / rdiv[i]) % 4;
  endfunction

  task automatic step();
    logic        r_pre;
    logic [15:0] v_pre;
    logic [3:0]  e_pre, d_pre;
    logic [3:0]  ea, ga;
    logic [6:0]  es, gs;
    logic        ed, gd;
    int          s;
    r_pre = rst; v_pre = value; e_pre = digit_en; d_pre = dp_in;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      ea = 4'b1111; es = 7'h7F; ed = 1'b1;
      if (r_pre) begin
        t_m[i] = 0;
      end else begin
        t_m[i] = t_m[i] + 1;
        if (t_m[i] > 1) begin
          s = ((t_m[i] - 1) / rdiv[i]) % 4;
          if (se_m[i][s]) begin
            ea = 4'b1111;
            ea[s] = 1'b0;
            es = hex_tab[(sv_m[i] >> (4 * s)) & 16'hF];
            ed = ~sd_m[i][s];
          end
        end
        if (t_m[i] == 1 || (t_m[i] % (4 * rdiv[i])) == 0) begin
          sv_m[i] = v_pre; se_m[i] = e_pre; sd_m[i] = d_pre;
        end
      end
      ga = (i == 0) ? an4 : an1;
      gs = (i == 0) ? seg4 : seg1;
      gd = (i == 0) ? dp4 : dp1;
      chk((i == 0) ? "an_div4" : "an_div1", 32'(ga), 32'(ea));
      chk((i == 0) ? "seg_div4" : "seg_div1", 32'(gs), 32'(es));
      chk((i == 0) ? "dp_div4" : "dp_div1", 32'(gd), 32'(ed));
      chk("an_onehot", 32'($countones(~ga) <= 1), 32'd1);
    end
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 2; i++) begin
      t_m[i] = 0; sv_m[i] = 16'h0; se_m[i] = 4'h0; sd_m[i] = 4'h0;
    end
    rst = 1'b1; value = 16'h1234; digit_en = 4'b1111; dp_in = 4'b0000;

    // Reset and first display
    repeat (3) step();
    chk("rst_an", 32'(an4), 32'hF);
    chk("rst_seg", 32'(seg4), 32'h7F);
    rst = 1'b0;
    step();
    chk("post1_an", 32'(an4), 32'hF);
    step();
    chk("first_an", 32'(an4), 32'hE);
    chk("first_seg", 32'(seg4), 32'h19);
    chk("first_dp", 32'(dp4), 32'h1);
    repeat (4) step();
    chk("second_an", 32'(an4), 32'hD);
    chk("second_seg", 32'(seg4), 32'h30);

    // Full scan order over two frames
    repeat (26) step();

    // Tearing immunity: change value while digit 1 is selected
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (cur_sel(0) == 1) found = 1'b1;
      else step();
    end
    chk("wait_sel1", 32'(found), 32'd1);
    value = 16'hABCD;
    repeat (40) step();

    // Hex table, one nibble per frame on the fast instance
    for (int k = 0; k < 16; k++) begin
      value = {value[15:4], 4'(k)};
      repeat (4) step();
    end

    // Blanking and decimal point
    digit_en = 4'b0101; dp_in = 4'b0001;
    repeat (36) step();

    // Reset mid-scan with digit 2 selected
    digit_en = 4'b1111; dp_in = 4'b0000; value = 16'h1234;
    repeat (16) step();
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (cur_sel(0) == 2) found = 1'b1;
      else step();
    end
    chk("wait_sel2", 32'(found), 32'd1);
    rst = 1'b1;
    step();
    chk("midrst_an", 32'(an4), 32'hF);
    rst = 1'b0; value = 16'h5678;
    step();
    step();
    chk("resume_an", 32'(an4), 32'hE);
    chk("resume_seg", 32'(seg4), 32'h00);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      value    = 16'($urandom);
      digit_en = 4'($urandom);
      dp_in    = 4'($urandom);
      rst      = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
- Downstream display stage for the 4-bit counter: takes four 4-bit nibbles and drives a 4-digit, common-anode, multiplexed seven-segment display.
- Each nibble is shown as a hex glyph. The counter output normally feeds the digit-0 nibble.
- Inputs are snapshotted once per scan frame, so a value changing mid-scan never tears across digits.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (100 MHz gives 1 kHz per digit, 250 Hz per frame); legal range >= 1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- value  input  16  four nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- digit_en  input  4  per-digit enable; 0 blanks that digit.
- dp_in  input  4  per-digit decimal point request; 1 = lit.
- an  output  4  anode selects, active-low, at most one bit low.
- seg  output  7  cathodes, active-low, seg[0]=a … seg[6]=g.
- dp  output  1  decimal point cathode, active-low.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high; clock and reset ports are named clk and rst.
  - All state is updated on the rising edge of clk only.
- Reset values:
  - div_cnt=0, sel=0, snap_value=0, snap_en=0, snap_dp=0, init_pending=1.
  - Outputs: an=4'b1111, seg=7'b1111111, dp=1.
- Divider:
  - div_cnt is $clog2(REFRESH_DIV) bits wide, minimum 1.
  - div_cnt increments every cycle.
  - When div_cnt==REFRESH_DIV-1: tick=1 and div_cnt wraps to 0.
  - With REFRESH_DIV=1, tick is asserted every cycle.
- Digit select:
  - sel is 2 bits and advances on tick, wrapping 3->0.
  - Frame length is 4*REFRESH_DIV cycles.
- Snapshot:
  - snap_value, snap_en and snap_dp load from value, digit_en and dp_in when load = init_pending | (tick & sel==3).
  - init_pending clears on the first non-reset cycle, so the first capture happens on that cycle.
  - Input changes at any other time are ignored until the next frame wrap.
- Output register, 1-cycle latency from sel/snapshot state:
  - If init_pending=1 or snap_en[sel]=0: an=1111, seg=1111111, dp=1.
  - Otherwise:
    - an = ~(4'b0001 << sel)
    - seg = hex(snap_value[4*sel+:4])
    - dp = ~snap_dp[sel]
- hex() encoding, as seg[6:0] in hex:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Boundary conditions:
  - rst asserted mid-frame: on the next edge, outputs blank and all state takes its reset values; scan restarts at digit 0 with a fresh capture.
  - tick on the same cycle as load (sel==3): the captured data is shown starting with digit 0 of the new frame.
  - All digit_en=0: an stays 1111 while the divider and sel keep running.
  - No combinational path from inputs to outputs.

Test Plan:
- Reset and first display:
  - Stimulus: REFRESH_DIV=4, value=16'h1234, digit_en=1111, dp_in=0000; hold rst for 3 cycles, then release.
  - Required: outputs all-ones during reset and on the 1st post-reset edge. After the 2nd edge, an=1110, seg=7'h19 (digit 0, glyph "4"), dp=1.
  - Required: four cycles later, an=1101, seg=7'h30 (digit 1, glyph "3").
- Full scan order:
  - Stimulus: same setup, run 2 frames (32 cycles).
  - Required: an sequence 1110, 1101, 1011, 0111 repeating, each held exactly 4 cycles; seg sequence 19, 30, 24, 79; at most one an bit low at any time.
- Hex table:
  - Stimulus: REFRESH_DIV=1; drive value with digit 0 = k for k=0..F, changing k each frame.
  - Required: each digit-0 slot shows seg equal to the listed code for k (e.g. A→08, F→0E).
- Tearing immunity:
  - Stimulus: change value from 16'h1234 to 16'hABCD while sel==1.
  - Required: digits 2 and 3 still show 2 and 1 in that frame; the next frame shows D, C, b, A (seg 21, 46, 03, 08).
- Blanking and decimal point:
  - Stimulus: digit_en=0101, dp_in=0001.
  - Required: during digit-1 and digit-3 slots, an=1111 and seg=7F; during the digit-0 slot, dp=0; during the digit-2 slot, dp=1.
- Reset mid-scan:
  - Stimulus: assert rst for 1 cycle while sel==2.
  - Required: blank outputs on the next edge; scan resumes at digit 0 (an=1110) two edges after rst deasserts, with a freshly captured value.
